floppy_track_loader: RTL and testbench
======================================

FLOPPY_TRACK_LOADER -- requirements
Module: floppy_track_loader

Interface
REQ-001 SHALL have parameter TRACK_BLOCKS, default 13, meaning 512-byte SD blocks per track (13*512 = 6656 bytes).
REQ-002 SHALL have parameter MAX_TRACK, default 34, meaning highest valid track; larger TRACK values clamp to MAX_TRACK.
REQ-003 SHALL have port CLK_14M in 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port RESET in 1, asynchronous, active-high.
REQ-005 SHALL have port DISK_MOUNT in 1: level, image present on SD.
REQ-006 SHALL have port ACTIVE in 1: drive motor active.
REQ-007 SHALL have port TRACK in 6: track requested by the drive.
REQ-008 SHALL have port TRACK_ADDR in 13: drive-side byte address.
REQ-009 SHALL have port TRACK_DI in 8: drive write data.
REQ-010 SHALL have port TRACK_WE in 1: drive write strobe.
REQ-011 SHALL have port TRACK_DO out 8: drive read data.
REQ-012 SHALL have port TRACK_BUSY out 1: track buffer not valid for drive.
REQ-013 SHALL have port DISK_READY out 1: mounted and a track is loaded.
REQ-014 SHALL have port SD_LBA out 32: block address of the current request.
REQ-015 SHALL have ports SD_RD out 1 and SD_WR out 1: block read/write requests.
REQ-016 SHALL have port SD_ACK in 1: host is servicing the request.
REQ-017 SHALL have ports SD_BUFF_ADDR in 9, SD_BUFF_DOUT in 8, SD_BUFF_WR in 1: host byte stream into the block.
REQ-018 SHALL have port SD_BUFF_DIN out 8: byte supplied to the host on writes.

Function
REQ-019 Track buffer SHALL be a dual-port RAM of 8192x8; drive port at TRACK_ADDR, host port at {blk[3:0],SD_BUFF_ADDR}.
REQ-020 TRACK_DO and SD_BUFF_DIN SHALL be registered reads, 1-cycle latency.
REQ-021 FSM states SHALL be IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT.
REQ-022 IDLE -> WR_REQ when DISK_MOUNT=1, a track is loaded, dirty=1, and either clamped TRACK != loaded track or ACTIVE falls.
REQ-023 IDLE -> RD_REQ when DISK_MOUNT=1 and (no track loaded or clamped TRACK != loaded track) and dirty=0.
REQ-024 In each REQ state SD_LBA SHALL equal track*TRACK_BLOCKS + blk (track = loaded track for writes, target track for reads), with SD_RD/SD_WR held 1 until SD_ACK=1, then cleared.
REQ-025 WAIT state SHALL end on SD_ACK falling; then blk increments; blk = TRACK_BLOCKS-1 completes the pass; blk resets to 0 at every pass start.
REQ-026 Write pass completion SHALL clear dirty and go to RD_REQ if the track differs, else IDLE.
REQ-027 Read pass completion SHALL latch target track as loaded, set valid, go IDLE.
REQ-028 Target track SHALL be sampled at RD_REQ entry of blk 0; TRACK changes mid-pass are handled after the pass.
REQ-029 RAM host-side writes SHALL occur only when SD_BUFF_WR=1, SD_ACK=1, state RD_WAIT.
REQ-030 TRACK_BUSY SHALL be 1 whenever state != IDLE or no track is loaded, and SHALL rise the same cycle a transition out of IDLE is taken.
REQ-031 Drive writes SHALL update RAM and set dirty only when TRACK_WE=1 and TRACK_BUSY=0 in that cycle; writes while busy are dropped.
REQ-032 DISK_READY SHALL equal DISK_MOUNT and valid.
REQ-033 DISK_MOUNT falling SHALL: in REQ states drop requests and go IDLE immediately; in WAIT states finish the SD_ACK handshake first; then clear valid and dirty (no flush).

Reset
REQ-034 On RESET: state IDLE, blk 0, valid 0, dirty 0, SD_RD 0, SD_WR 0, SD_LBA 0, TRACK_DO 0, SD_BUFF_DIN 0, TRACK_BUSY 1, DISK_READY 0; an in-flight request is abandoned; RAM contents undefined.

Verification
REQ-035 Mount, TRACK=0 -> 13 SD_RD requests, LBA 0..12, then TRACK_BUSY=0, DISK_READY=1; TRACK_ADDR=0x0000 reads first loaded byte.
REQ-036 Loaded track 3, write 0xA5 at 0x0100, set TRACK=4 -> SD_WR LBA 39..51 with byte 0xA5 at block 39 offset 0x100, then SD_RD LBA 52..64.
REQ-037 TRACK=50 -> clamped to 34, SD_RD LBA 442..454.
REQ-038 TRACK_WE pulse while TRACK_BUSY=1 -> RAM unchanged, dirty stays 0, no SD_WR later.
REQ-039 Dirty track 5, ACTIVE 1->0 -> SD_WR LBA 65..77, dirty cleared, no reread.
REQ-040 RESET asserted during RD_WAIT of block 6 -> SD_RD=0 immediately, DISK_READY=0; after release full reread from LBA track*13.

Source files
------------

// File: rtl/floppy_track_loader.sv
// floppy_track_loader
//   Caches one floppy track (TRACK_BLOCKS x 512 bytes) from an SD-card disk
//   image in a dual-port RAM. The buffer is reloaded whenever the drive asks
//   for a different track. If the drive has written to the buffer, the buffer
//   is flushed back to the image first. A flush also happens when the motor
//   stops.
//
// Ports
//   CLK_14M                  single clock, rising edge
//   RESET                    asynchronous, active-high
//   DISK_MOUNT               level: image present on SD
//   ACTIVE                   drive motor active (falling edge triggers a flush)
//   TRACK[5:0]               track requested by the drive (clamped to MAX_TRACK)
//   TRACK_ADDR[12:0]         drive-side byte address
//   TRACK_DI[7:0], TRACK_WE  drive write data / strobe (dropped while busy)
//   TRACK_DO[7:0]            drive read data, one cycle after TRACK_ADDR
//   TRACK_BUSY               buffer not usable by the drive
//   DISK_READY               mounted and a track is loaded
//   SD_LBA[31:0]             block address of the current request
//   SD_RD, SD_WR             block read / write requests, held until SD_ACK
//   SD_ACK                   host is servicing the request
//   SD_BUFF_ADDR[8:0], SD_BUFF_DOUT[7:0], SD_BUFF_WR
//                            host byte stream into the current block
//   SD_BUFF_DIN[7:0]         byte supplied to the host on block writes,
//                            one cycle after SD_BUFF_ADDR

module floppy_track_loader #(
  parameter int TRACK_BLOCKS = 13,
  parameter int MAX_TRACK    = 34
) (
  input  logic        CLK_14M,
  input  logic        RESET,
  input  logic        DISK_MOUNT,
  input  logic        ACTIVE,
  input  logic [5:0]  TRACK,
  input  logic [12:0] TRACK_ADDR,
  input  logic [7:0]  TRACK_DI,
  input  logic        TRACK_WE,
  output logic [7:0]  TRACK_DO,
  output logic        TRACK_BUSY,
  output logic        DISK_READY,
  output logic [31:0] SD_LBA,
  output logic        SD_RD,
  output logic        SD_WR,
  input  logic        SD_ACK,
  input  logic [8:0]  SD_BUFF_ADDR,
  input  logic [7:0]  SD_BUFF_DOUT,
  input  logic        SD_BUFF_WR,
  output logic [7:0]  SD_BUFF_DIN
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_WAIT,
    RD_REQ,
    RD_WAIT
  } state_t;

  localparam logic [31:0] BLOCKS_32 = 32'(TRACK_BLOCKS);
  localparam logic [3:0]  LAST_BLK  = 4'(TRACK_BLOCKS - 1);
  localparam logic [5:0]  MAX_TRK   = 6'(MAX_TRACK);

  state_t      state, state_n;
  logic [3:0]  blk, blk_n;
  logic [5:0]  loaded_trk, loaded_trk_n;
  logic [5:0]  target_trk, target_trk_n;
  logic        valid, valid_n;
  logic        dirty, dirty_n;
  logic        sd_rd, sd_rd_n;
  logic        sd_wr, sd_wr_n;
  logic [31:0] sd_lba, sd_lba_n;
  logic        mount_lost, mount_lost_n;
  logic        active_q;
  logic        ack_q;

  logic [5:0]  trk_c;
  logic        active_fall;
  logic        ack_fall;
  logic        wr_start;
  logic        rd_start;
  logic        busy;
  logic        drive_we;
  logic        host_we;
  logic [12:0] host_addr;

  logic [7:0]  ram [0:8191];

  function automatic logic [31:0] block_lba(input logic [5:0] trk, input logic [3:0] b);
    return (32'(trk) * BLOCKS_32) + 32'(b);
  endfunction

  assign trk_c       = (TRACK > MAX_TRK) ? MAX_TRK : TRACK;
  assign active_fall = active_q && !ACTIVE;
  assign ack_fall    = ack_q && !SD_ACK;

  // IDLE exit conditions. These are kept outside the FSM block so that
  // TRACK_BUSY can rise in the same cycle the exit is taken. That also blocks
  // a drive write racing the start of a pass.
  assign wr_start = DISK_MOUNT && valid && dirty &&
                    ((trk_c != loaded_trk) || active_fall);
  assign rd_start = DISK_MOUNT && !dirty &&
                    (!valid || (trk_c != loaded_trk));

  assign busy      = (state != IDLE) || !valid || wr_start || rd_start;
  assign drive_we  = TRACK_WE && !busy;
  assign host_we   = SD_BUFF_WR && SD_ACK && (state == RD_WAIT);
  assign host_addr = {blk, SD_BUFF_ADDR};

  assign TRACK_BUSY = busy;
  assign DISK_READY = DISK_MOUNT && valid;
  assign SD_RD      = sd_rd;
  assign SD_WR      = sd_wr;
  assign SD_LBA     = sd_lba;

  always_comb begin
    state_n      = state;
    blk_n        = blk;
    loaded_trk_n = loaded_trk;
    target_trk_n = target_trk;
    valid_n      = valid;
    dirty_n      = dirty;
    sd_rd_n      = sd_rd;
    sd_wr_n      = sd_wr;
    sd_lba_n     = sd_lba;
    mount_lost_n = mount_lost;

    unique case (state)
      IDLE: begin
        mount_lost_n = 1'b0;
        if (!DISK_MOUNT) begin
          valid_n = 1'b0;
          dirty_n = 1'b0;
        end else if (wr_start) begin
          state_n  = WR_REQ;
          blk_n    = '0;
          sd_wr_n  = 1'b1;
          sd_lba_n = block_lba(loaded_trk, '0);
        end else if (rd_start) begin
          state_n      = RD_REQ;
          blk_n        = '0;
          target_trk_n = trk_c;
          sd_rd_n      = 1'b1;
          sd_lba_n     = block_lba(trk_c, '0);
        end else if (drive_we) begin
          dirty_n = 1'b1;
        end
      end

      WR_REQ: begin
        if (!DISK_MOUNT) begin
          state_n = IDLE;
          sd_wr_n = 1'b0;
          valid_n = 1'b0;
          dirty_n = 1'b0;
        end else if (SD_ACK) begin
          state_n = WR_WAIT;
          sd_wr_n = 1'b0;
        end
      end

      WR_WAIT: begin
        // An unmount seen mid-block is remembered until the host lets go of SD_ACK.
        if (!DISK_MOUNT) mount_lost_n = 1'b1;
        if (ack_fall) begin
          if (mount_lost || !DISK_MOUNT) begin
            state_n = IDLE;
            valid_n = 1'b0;
            dirty_n = 1'b0;
          end else if (blk == LAST_BLK) begin
            dirty_n = 1'b0;
            if (trk_c != loaded_trk) begin
              state_n      = RD_REQ;
              blk_n        = '0;
              target_trk_n = trk_c;
              sd_rd_n      = 1'b1;
              sd_lba_n     = block_lba(trk_c, '0);
            end else begin
              state_n = IDLE;
            end
          end else begin
            state_n  = WR_REQ;
            blk_n    = blk + 4'd1;
            sd_wr_n  = 1'b1;
            sd_lba_n = block_lba(loaded_trk, blk + 4'd1);
          end
        end
      end

      RD_REQ: begin
        if (!DISK_MOUNT) begin
          state_n = IDLE;
          sd_rd_n = 1'b0;
          valid_n = 1'b0;
          dirty_n = 1'b0;
        end else if (SD_ACK) begin
          state_n = RD_WAIT;
          sd_rd_n = 1'b0;
        end
      end

      RD_WAIT: begin
        if (!DISK_MOUNT) mount_lost_n = 1'b1;
        if (ack_fall) begin
          if (mount_lost || !DISK_MOUNT) begin
            state_n = IDLE;
            valid_n = 1'b0;
            dirty_n = 1'b0;
          end else if (blk == LAST_BLK) begin
            state_n      = IDLE;
            loaded_trk_n = target_trk;
            valid_n      = 1'b1;
          end else begin
            state_n  = RD_REQ;
            blk_n    = blk + 4'd1;
            sd_rd_n  = 1'b1;
            sd_lba_n = block_lba(target_trk, blk + 4'd1);
          end
        end
      end

      default: begin
        state_n = IDLE;
        sd_rd_n = 1'b0;
        sd_wr_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK_14M or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      blk        <= '0;
      loaded_trk <= '0;
      target_trk <= '0;
      valid      <= 1'b0;
      dirty      <= 1'b0;
      sd_rd      <= 1'b0;
      sd_wr      <= 1'b0;
      sd_lba     <= '0;
      mount_lost <= 1'b0;
      active_q   <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state      <= state_n;
      blk        <= blk_n;
      loaded_trk <= loaded_trk_n;
      target_trk <= target_trk_n;
      valid      <= valid_n;
      dirty      <= dirty_n;
      sd_rd      <= sd_rd_n;
      sd_wr      <= sd_wr_n;
      sd_lba     <= sd_lba_n;
      mount_lost <= mount_lost_n;
      active_q   <= ACTIVE;
      ack_q      <= SD_ACK;
    end
  end

  // Drive writes need IDLE and host writes need RD_WAIT. The two never
  // coincide, so each port has its own write address.
  always_ff @(posedge CLK_14M) begin
    if (drive_we) ram[TRACK_ADDR] <= TRACK_DI;
    if (host_we)  ram[host_addr]  <= SD_BUFF_DOUT;
  end

  always_ff @(posedge CLK_14M or posedge RESET) begin
    if (RESET) begin
      TRACK_DO    <= '0;
      SD_BUFF_DIN <= '0;
    end else begin
      TRACK_DO    <= ram[TRACK_ADDR];
      SD_BUFF_DIN <= ram[host_addr];
    end
  end

endmodule

// File: tb/tb_floppy_track_loader.sv
// tb_floppy_track_loader
//   Drives floppy_track_loader against an emulated SD host that holds a random
//   disk image. Expected SD request sequences, image contents and drive-side
//   read data come from a track-level model: a track load copies an image
//   region into the buffer and a flush copies the buffer back.

module tb_floppy_track_loader;

  localparam int BLKS      = 13;
  localparam int TRK_BYTES = BLKS * 512;
  localparam int N_TRK     = 35;
  localparam int IMG_BYTES = N_TRK * TRK_BYTES;

  logic        CLK_14M = 1'b0;
  logic        RESET;
  logic        DISK_MOUNT;
  logic        ACTIVE;
  logic [5:0]  TRACK;
  logic [12:0] TRACK_ADDR;
  logic [7:0]  TRACK_DI;
  logic        TRACK_WE;
  logic [7:0]  TRACK_DO;
  logic        TRACK_BUSY;
  logic        DISK_READY;
  logic [31:0] SD_LBA;
  logic        SD_RD;
  logic        SD_WR;
  logic        SD_ACK;
  logic [8:0]  SD_BUFF_ADDR;
  logic [7:0]  SD_BUFF_DOUT;
  logic        SD_BUFF_WR;
  logic [7:0]  SD_BUFF_DIN;

  floppy_track_loader #(.TRACK_BLOCKS(13), .MAX_TRACK(34)) dut (
    .CLK_14M     (CLK_14M),
    .RESET       (RESET),
    .DISK_MOUNT  (DISK_MOUNT),
    .ACTIVE      (ACTIVE),
    .TRACK       (TRACK),
    .TRACK_ADDR  (TRACK_ADDR),
    .TRACK_DI    (TRACK_DI),
    .TRACK_WE    (TRACK_WE),
    .TRACK_DO    (TRACK_DO),
    .TRACK_BUSY  (TRACK_BUSY),
    .DISK_READY  (DISK_READY),
    .SD_LBA      (SD_LBA),
    .SD_RD       (SD_RD),
    .SD_WR       (SD_WR),
    .SD_ACK      (SD_ACK),
    .SD_BUFF_ADDR(SD_BUFF_ADDR),
    .SD_BUFF_DOUT(SD_BUFF_DOUT),
    .SD_BUFF_WR  (SD_BUFF_WR),
    .SD_BUFF_DIN (SD_BUFF_DIN)
  );

  always #5 CLK_14M = ~CLK_14M;

  logic [7:0]  img     [0:IMG_BYTES-1];  // disk as written by the emulated host
  logic [7:0]  exp_img [0:IMG_BYTES-1];  // disk as the model predicts it
  logic [7:0]  buf_m   [0:TRK_BYTES-1];  // model of the drive-visible buffer
  logic [32:0] req_log [$];              // {is_write, lba} seen by the host
  logic [32:0] exp_log [$];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_val(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_load(int t);
    for (int b = 0; b < BLKS; b++) exp_log.push_back({1'b0, 32'(t * BLKS + b)});
    for (int i = 0; i < TRK_BYTES; i++) buf_m[i] = exp_img[t * TRK_BYTES + i];
  endtask

  task automatic model_flush(int t);
    for (int b = 0; b < BLKS; b++) exp_log.push_back({1'b1, 32'(t * BLKS + b)});
    for (int i = 0; i < TRK_BYTES; i++) exp_img[t * TRK_BYTES + i] = buf_m[i];
  endtask

  function automatic int trk_mism(int t);
    int n = 0;
    for (int i = 0; i < TRK_BYTES; i++)
      if (img[t * TRK_BYTES + i] !== exp_img[t * TRK_BYTES + i]) n++;
    return n;
  endfunction

  // ---------------- emulated SD host ----------------
  logic        h_wr;
  logic [31:0] h_lba;

  initial begin
    SD_ACK = 1'b0; SD_BUFF_WR = 1'b0; SD_BUFF_ADDR = '0; SD_BUFF_DOUT = '0;
    forever begin
      @(negedge CLK_14M);
      if (!RESET && (SD_RD || SD_WR)) begin
        h_wr  = SD_WR;
        h_lba = SD_LBA;
        req_log.push_back({h_wr, h_lba});
        SD_ACK = 1'b1;
        for (int i = 0; i <= 512; i++) begin
          @(negedge CLK_14M);
          if (RESET) break;
          if (h_wr) begin
            if (i > 0)   img[int'(h_lba) * 512 + i - 1] = SD_BUFF_DIN;
            if (i < 512) SD_BUFF_ADDR = 9'(i);
          end else if (i < 512) begin
            SD_BUFF_ADDR = 9'(i);
            SD_BUFF_DOUT = img[int'(h_lba) * 512 + i];
            SD_BUFF_WR   = 1'b1;
          end else begin
            SD_BUFF_WR = 1'b0;
          end
        end
        SD_ACK     = 1'b0;
        SD_BUFF_WR = 1'b0;
      end
    end
  end

  // ---------------- drive-side helpers ----------------
  task automatic drive_write(input logic [12:0] a, input logic [7:0] d);
    TRACK_ADDR = a; TRACK_DI = d; TRACK_WE = 1'b1;
    @(negedge CLK_14M);
    TRACK_WE = 1'b0;
  endtask

  task automatic drive_read(input logic [12:0] a, output logic [7:0] d);
    TRACK_ADDR = a;
    @(negedge CLK_14M);
    d = TRACK_DO;
  endtask

  task automatic check_buf(string tag, int n);
    logic [12:0] a;
    logic [7:0]  d;
    for (int k = 0; k < n; k++) begin
      a = 13'($urandom_range(0, TRK_BYTES - 1));
      drive_read(a, d);
      check_val($sformatf("%s_buf%0h", tag, a), d, buf_m[a]);
    end
  endtask

  task automatic check_reqs(string tag);
    check_val({tag, "_nreq"}, req_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < req_log.size(); i++)
      check_val($sformatf("%s_req%0d", tag, i), req_log[i], exp_log[i]);
    req_log.delete();
    exp_log.delete();
  endtask

  task automatic wait_idle(string tag);
    int n = 0;
    @(negedge CLK_14M);
    while (TRACK_BUSY && n < 20000) begin
      @(negedge CLK_14M);
      n++;
    end
    check_val({tag, "_idle"}, TRACK_BUSY, 0);
    repeat (4) @(negedge CLK_14M);
  endtask

  task automatic wait_lba(string tag, int lba);
    int n = 0;
    logic seen = 1'b0;
    while (!seen && n < 20000) begin
      @(negedge CLK_14M);
      seen = SD_ACK && !SD_RD && (SD_LBA == 32'(lba));
      n++;
    end
    check_val({tag, "_seen"}, seen, 1);
  endtask

  // ---------------- scenarios ----------------
  logic [7:0]  d;
  logic [12:0] a;
  int          t;

  initial begin
    RESET = 1'b1; DISK_MOUNT = 1'b0; ACTIVE = 1'b1; TRACK = '0;
    TRACK_ADDR = '0; TRACK_DI = '0; TRACK_WE = 1'b0;
    for (int i = 0; i < IMG_BYTES; i++) begin
      img[i]     = 8'($urandom);
      exp_img[i] = img[i];
    end
    repeat (3) @(negedge CLK_14M);
    check_val("rst_sd_rd", SD_RD, 0);
    check_val("rst_sd_wr", SD_WR, 0);
    check_val("rst_sd_lba", SD_LBA, 0);
    check_val("rst_track_do", TRACK_DO, 0);
    check_val("rst_buff_din", SD_BUFF_DIN, 0);
    check_val("rst_busy", TRACK_BUSY, 1);
    check_val("rst_ready", DISK_READY, 0);
    RESET = 1'b0;
    repeat (5) @(negedge CLK_14M);
    check_val("unmounted_busy", TRACK_BUSY, 1);
    check_val("unmounted_nreq", req_log.size(), 0);

    // Mount with track 0.
    DISK_MOUNT = 1'b1; TRACK = 6'd0;
    model_load(0);
    wait_idle("mount");
    check_reqs("mount");
    check_val("mount_ready", DISK_READY, 1);
    drive_read(13'h0000, d);
    check_val("mount_byte0", d, exp_img[0]);
    check_buf("mount", 6);

    // Track 3, dirty it, step to 4: flush 39..51 then read 52..64.
    TRACK = 6'd3;
    model_load(3);
    wait_idle("trk3");
    check_reqs("trk3");
    drive_write(13'h0100, 8'hA5);
    buf_m[13'h0100] = 8'hA5;
    for (int k = 0; k < 3; k++) begin
      a = 13'($urandom_range(13'h200, TRK_BYTES - 1));
      d = 8'($urandom);
      drive_write(a, d);
      buf_m[a] = d;
    end
    TRACK = 6'd4;
    model_flush(3);
    model_load(4);
    wait_idle("step4");
    check_reqs("step4");
    check_val("step4_a5", img[39 * 512 + 256], 8'hA5);
    check_val("step4_img", trk_mism(3), 0);
    check_buf("trk4", 6);

    // Out-of-range track clamps to 34.
    TRACK = 6'd50;
    model_load(34);
    wait_idle("clamp");
    check_reqs("clamp");
    check_buf("clamp", 4);

    // Drive write during a load is dropped and leaves the track clean.
    TRACK = 6'd5;
    model_load(5);
    wait_lba("busywe", 5 * BLKS + 1);
    a = 13'($urandom_range(0, 511));
    check_val("busywe_busy", TRACK_BUSY, 1);
    drive_write(a, ~exp_img[5 * TRK_BYTES + a]);
    wait_idle("busywe");
    check_reqs("busywe");
    drive_read(a, d);
    check_val("busywe_ram", d, buf_m[a]);
    ACTIVE = 1'b0;
    repeat (30) @(negedge CLK_14M);
    check_val("busywe_nowr", req_log.size(), 0);
    ACTIVE = 1'b1;
    repeat (2) @(negedge CLK_14M);

    // Dirty track 5, motor stops: flush 65..77, no reread.
    for (int k = 0; k < 4; k++) begin
      a = 13'($urandom_range(0, TRK_BYTES - 1));
      d = 8'($urandom);
      drive_write(a, d);
      buf_m[a] = d;
    end
    ACTIVE = 1'b0;
    model_flush(5);
    wait_idle("motor");
    check_reqs("motor");
    check_val("motor_img", trk_mism(5), 0);
    check_buf("motor", 4);
    ACTIVE = 1'b1;
    repeat (2) @(negedge CLK_14M);
    ACTIVE = 1'b0;
    repeat (30) @(negedge CLK_14M);
    check_val("motor_clean_nreq", req_log.size(), 0);
    ACTIVE = 1'b1;

    // Reset in the middle of block 6 of a load, then a full reload.
    t = $urandom_range(0, 33);
    if (t >= 5) t++;
    TRACK = 6'(t);
    for (int b = 0; b <= 6; b++) exp_log.push_back({1'b0, 32'(t * BLKS + b)});
    wait_lba("rstmid", t * BLKS + 6);
    repeat (50) @(negedge CLK_14M);
    RESET = 1'b1;
    #1;
    check_val("rstmid_sd_rd", SD_RD, 0);
    check_val("rstmid_ready", DISK_READY, 0);
    check_val("rstmid_busy", TRACK_BUSY, 1);
    repeat (3) @(negedge CLK_14M);
    RESET = 1'b0;
    model_load(t);
    wait_idle("reload");
    check_reqs("reload");
    check_val("reload_ready", DISK_READY, 1);
    check_buf("reload", 6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
